// File: rtl/rx_symbol_aligner.sv
// Per-lane 8b/10b receive symbol aligner: finds K28.5 at any of 10 bit offsets,
// acquires symbol lock, emits aligned symbols and drops lock on repeated errors.
//
// state       | meaning
// S_UNALIGNED | searching all offsets for a comma
// S_CHECK     | candidate offset held, counting same-offset commas
// S_LOCKED    | offset frozen, symbols emitted, errors counted
module rx_symbol_aligner #(
  parameter int LOCK_COMMAS = 2,
  parameter int ERR_THRESH  = 4,
  parameter int GOOD_WINDOW = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [9:0] raw_word_i,
  input  logic       raw_valid_i,
  input  logic       code_err_i,
  output logic [9:0] aligned_symbol_o,
  output logic       aligned_valid_o,
  output logic       is_comma_o,
  output logic       symbol_lock_o,
  output logic [3:0] align_offset_o,
  output logic       lock_lost_o
);

  localparam logic [9:0] K_RDN  = 10'h17C;
  localparam logic [9:0] K_RDP  = 10'h283;
  localparam logic [3:0] LOCK_N = 4'(LOCK_COMMAS);
  localparam logic [3:0] ERR_N  = 4'(ERR_THRESH);
  localparam logic [7:0] GOOD_N = 8'(GOOD_WINDOW);

  typedef enum logic [1:0] {S_UNALIGNED, S_CHECK, S_LOCKED} state_t;

  state_t     r_state;
  logic [9:0] r_prev;
  logic       r_prev_seen;
  logic [3:0] r_offset;
  logic [3:0] r_cnt;
  logic [3:0] r_err_cnt;
  logic [7:0] r_good_cnt;
  logic [9:0] r_symbol;
  logic       r_valid;
  logic       r_comma;
  logic       r_lost;

  logic [19:0] w_win;
  logic [9:0]  w_cand [10];
  logic [9:0]  w_match;
  logic        w_any;
  logic [3:0]  w_lowest;
  logic        w_at_cur;
  logic [3:0]  w_new_offset;
  logic [9:0]  w_sym;
  logic        w_sym_comma;
  logic        w_err;
  logic        w_err_hit;
  logic        w_cnt_hit;
  logic        w_good_hit;
  logic        w_go_locked;

  assign w_win = {raw_word_i, r_prev};

  always_comb begin
    for (int k = 0; k < 10; k++) begin
      w_cand[k]  = w_win[k +: 10];
      w_match[k] = (w_cand[k] == K_RDN) || (w_cand[k] == K_RDP);
    end
  end

  assign w_any = |w_match;

  // Scan downwards so the lowest matching offset is the one that sticks.
  always_comb begin
    w_lowest = 4'd0;
    for (int k = 9; k >= 0; k--) begin
      if (w_match[k]) w_lowest = 4'(k);
    end
  end

  always_comb begin
    w_at_cur = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (r_offset == 4'(k)) w_at_cur = w_match[k];
    end
  end

  always_comb begin
    w_new_offset = r_offset;
    if (w_any && (r_state == S_UNALIGNED || (r_state == S_CHECK && !w_at_cur)))
      w_new_offset = w_lowest;
  end

  always_comb begin
    w_sym = 10'd0;
    for (int k = 0; k < 10; k++) begin
      if (w_new_offset == 4'(k)) w_sym = w_cand[k];
    end
  end

  assign w_sym_comma = (w_sym == K_RDN) || (w_sym == K_RDP);
  assign w_err       = code_err_i || (w_any && !w_at_cur);
  assign w_err_hit   = (4'(r_err_cnt + 4'd1) == ERR_N);
  assign w_cnt_hit   = (4'(r_cnt + 4'd1) == LOCK_N);
  assign w_good_hit  = (8'(r_good_cnt + 8'd1) == GOOD_N);

  always_comb begin
    w_go_locked = 1'b0;
    case (r_state)
      S_UNALIGNED: w_go_locked = w_any && (LOCK_COMMAS == 1);
      S_CHECK:     w_go_locked = w_at_cur && w_cnt_hit;
      S_LOCKED:    w_go_locked = !(w_err && w_err_hit);
      default:     w_go_locked = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_UNALIGNED;
      r_prev      <= 10'd0;
      r_prev_seen <= 1'b0;
      r_offset    <= 4'd0;
      r_cnt       <= 4'd0;
      r_err_cnt   <= 4'd0;
      r_good_cnt  <= 8'd0;
      r_symbol    <= 10'd0;
      r_valid     <= 1'b0;
      r_comma     <= 1'b0;
      r_lost      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_comma <= 1'b0;
      r_lost  <= 1'b0;
      if (raw_valid_i) begin
        r_prev      <= raw_word_i;
        r_prev_seen <= 1'b1;
        if (r_prev_seen) begin
          r_symbol <= w_sym;
          r_valid  <= w_go_locked;
          r_comma  <= w_go_locked && w_sym_comma;
          r_offset <= w_new_offset;
          case (r_state)
            S_UNALIGNED: begin
              if (w_any) begin
                r_cnt   <= 4'd1;
                r_state <= (LOCK_COMMAS == 1) ? S_LOCKED : S_CHECK;
              end
            end
            S_CHECK: begin
              if (w_at_cur) begin
                r_cnt <= 4'(r_cnt + 4'd1);
                if (w_cnt_hit) begin
                  r_state    <= S_LOCKED;
                  r_err_cnt  <= 4'd0;
                  r_good_cnt <= 8'd0;
                end
              end else if (w_any) begin
                r_cnt <= 4'd1;
              end
            end
            S_LOCKED: begin
              if (w_err) begin
                if (w_err_hit) begin
                  r_state    <= S_UNALIGNED;
                  r_lost     <= 1'b1;
                  r_cnt      <= 4'd0;
                  r_err_cnt  <= 4'd0;
                  r_good_cnt <= 8'd0;
                end else begin
                  r_err_cnt  <= 4'(r_err_cnt + 4'd1);
                  r_good_cnt <= 8'd0;
                end
              end else if (w_good_hit) begin
                r_err_cnt  <= 4'd0;
                r_good_cnt <= 8'd0;
              end else begin
                r_good_cnt <= 8'(r_good_cnt + 8'd1);
              end
            end
            default: r_state <= S_UNALIGNED;
          endcase
        end
      end
    end
  end

  assign aligned_symbol_o = r_symbol;
  assign aligned_valid_o  = r_valid;
  assign is_comma_o       = r_comma;
  assign symbol_lock_o    = (r_state == S_LOCKED);
  assign align_offset_o   = r_offset;
  assign lock_lost_o      = r_lost;

endmodule

// File: tb/tb_rx_symbol_aligner.sv
// Directed bench for rx_symbol_aligner: symbols are serialised into a bit queue at
// a chosen phase, expected aligned outputs go into a scoreboard popped by a monitor.
module tb_rx_symbol_aligner;

  localparam logic [9:0] COM = 10'h17C;
  localparam logic [9:0] DAT = 10'h155;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [9:0] raw_word_i;
  logic       raw_valid_i;
  logic       code_err_i;
  logic [9:0] aligned_symbol_o;
  logic       aligned_valid_o;
  logic       is_comma_o;
  logic       symbol_lock_o;
  logic [3:0] align_offset_o;
  logic       lock_lost_o;

  int         n_pass = 0;
  int         n_total = 0;
  int         ll_count = 0;
  logic [9:0] exp_q[$];
  bit         bitq[$];
  logic [9:0] w_prev_sent = 10'd0;
  logic [9:0] w_cur_sent = 10'd0;

  rx_symbol_aligner dut (
    .clk_i(clk_i), .rst_i(rst_i), .raw_word_i(raw_word_i), .raw_valid_i(raw_valid_i),
    .code_err_i(code_err_i), .aligned_symbol_o(aligned_symbol_o),
    .aligned_valid_o(aligned_valid_o), .is_comma_o(is_comma_o),
    .symbol_lock_o(symbol_lock_o), .align_offset_o(align_offset_o),
    .lock_lost_o(lock_lost_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Monitor: every presented aligned symbol must match the next scoreboard entry.
  always @(negedge clk_i) begin
    logic [9:0] e;
    if (lock_lost_o) ll_count++;
    if (aligned_valid_o) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_output: got %h with empty scoreboard at %0t",
                 aligned_symbol_o, $time);
      end else begin
        e = exp_q.pop_front();
        check("aligned_symbol", aligned_symbol_o, e);
        check("is_comma", is_comma_o, (e == COM || e == 10'h283));
      end
    end
  end

  task automatic send_word(input logic [9:0] w, input logic err);
    @(negedge clk_i);
    raw_word_i  = w;
    raw_valid_i = 1'b1;
    code_err_i  = err;
    @(posedge clk_i);
    #1;
    raw_valid_i = 1'b0;
    code_err_i  = 1'b0;
    w_prev_sent = w_cur_sent;
    w_cur_sent  = w;
  endtask

  // Append one symbol to the serial stream and send the next 10-bit word.
  // When expo is set, the DUT must emit the window slice at offset off.
  task automatic put(input logic [9:0] sym, input logic err, input logic expo, input int off);
    logic [9:0]  w;
    logic [19:0] win;
    for (int i = 0; i < 10; i++) bitq.push_back(sym[i]);
    for (int i = 0; i < 10; i++) w[i] = bitq.pop_front();
    send_word(w, err);
    if (expo) begin
      win = {w_cur_sent, w_prev_sent};
      exp_q.push_back(win[off +: 10]);
    end
  endtask

  task automatic slip(input int n);
    for (int i = 0; i < n; i++) bitq.push_back(1'b0);
  endtask

  task automatic restart(input int k);
    bitq.delete();
    slip(k);
    w_cur_sent = 10'd0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic relock3();
    put(COM, 1'b0, 1'b0, 3);
    put(DAT, 1'b0, 1'b0, 3);
    put(COM, 1'b0, 1'b0, 3);
    put(DAT, 1'b0, 1'b1, 3);
    check("relock", symbol_lock_o, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1;
    raw_word_i = 10'd0;
    raw_valid_i = 1'b0;
    code_err_i = 1'b0;
    #1;
    check("rst_valid", aligned_valid_o, 1'b0);
    check("rst_lock", symbol_lock_o, 1'b0);
    check("rst_offset", align_offset_o, 4'd0);
    check("rst_symbol", aligned_symbol_o, 10'd0);
    check("rst_comma", is_comma_o, 1'b0);
    check("rst_lost", lock_lost_o, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Acquisition at offset 3, COM every 8 words.
    restart(3);
    put(DAT, 1'b0, 1'b0, 3);
    put(COM, 1'b0, 1'b0, 3);
    for (int i = 0; i < 7; i++) put(DAT, 1'b0, 1'b0, 3);
    check("check_offset", align_offset_o, 4'd3);
    check("check_nolock", symbol_lock_o, 1'b0);
    put(COM, 1'b0, 1'b0, 3);
    check("pre_lock", symbol_lock_o, 1'b0);
    put(DAT, 1'b0, 1'b1, 3);
    check("lock", symbol_lock_o, 1'b1);
    check("lock_offset", align_offset_o, 4'd3);
    check("first_symbol", aligned_symbol_o, 10'h17C);
    check("first_comma", is_comma_o, 1'b1);
    for (int i = 0; i < 3; i++) put(DAT, 1'b0, 1'b1, 3);

    // Four separated code errors drop lock on the 4th.
    for (int i = 0; i < 3; i++) begin
      put(DAT, 1'b1, 1'b1, 3);
      put(DAT, 1'b0, 1'b1, 3);
    end
    put(DAT, 1'b1, 1'b0, 3);
    check("lost_pulse", lock_lost_o, 1'b1);
    check("lost_lock", symbol_lock_o, 1'b0);
    check("lost_novalid", aligned_valid_o, 1'b0);
    put(DAT, 1'b0, 1'b0, 3);
    check("lost_pulse_end", lock_lost_o, 1'b0);
    check("lost_count1", ll_count, 1);

    // Three errors, a full good window, three more errors: lock held.
    relock3();
    for (int b = 0; b < 2; b++) begin
      put(DAT, 1'b1, 1'b1, 3);
      put(DAT, 1'b0, 1'b1, 3);
      put(DAT, 1'b1, 1'b1, 3);
      put(DAT, 1'b0, 1'b1, 3);
      put(DAT, 1'b1, 1'b1, 3);
      if (b == 0) for (int i = 0; i < 16; i++) put(DAT, 1'b0, 1'b1, 3);
    end
    check("window_held", symbol_lock_o, 1'b1);
    put(DAT, 1'b1, 1'b0, 3);
    check("window_4th_lost", symbol_lock_o, 1'b0);
    put(DAT, 1'b0, 1'b0, 3);
    check("lost_count2", ll_count, 2);

    // Code error together with a wrong-offset comma counts once per word.
    relock3();
    slip(4);
    for (int i = 0; i < 3; i++) begin
      put(COM, 1'b0, 1'b1, 3);
      put(DAT, 1'b1, 1'b1, 3);
      check("dual_err_held", symbol_lock_o, 1'b1);
    end
    check("frozen_offset", align_offset_o, 4'd3);
    put(COM, 1'b0, 1'b1, 3);
    put(DAT, 1'b1, 1'b0, 3);
    check("dual_err_lost", symbol_lock_o, 1'b0);
    check("dual_err_pulse", lock_lost_o, 1'b1);

    // Idle gaps change nothing; async reset mid-lock; relock from scratch.
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    restart(3);
    put(DAT, 1'b0, 1'b0, 3);
    put(COM, 1'b0, 1'b0, 3);
    gap(3);
    put(DAT, 1'b0, 1'b0, 3);
    check("gap_check_offset", align_offset_o, 4'd3);
    put(DAT, 1'b0, 1'b0, 3);
    put(DAT, 1'b0, 1'b0, 3);
    gap(2);
    check("gap_nolock", symbol_lock_o, 1'b0);
    put(COM, 1'b0, 1'b0, 3);
    gap(1);
    put(DAT, 1'b0, 1'b1, 3);
    check("gap_lock", symbol_lock_o, 1'b1);
    gap(4);
    check("gap_hold_lock", symbol_lock_o, 1'b1);
    check("gap_novalid", aligned_valid_o, 1'b0);
    put(DAT, 1'b0, 1'b1, 3);
    @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    #1;
    check("async_lock", symbol_lock_o, 1'b0);
    check("async_symbol", aligned_symbol_o, 10'd0);
    check("async_offset", align_offset_o, 4'd0);
    check("async_valid", aligned_valid_o, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    restart(3);
    put(DAT, 1'b0, 1'b0, 3);
    put(COM, 1'b0, 1'b0, 3);
    put(DAT, 1'b0, 1'b0, 3);
    put(COM, 1'b0, 1'b0, 3);
    check("relock_not_yet", symbol_lock_o, 1'b0);
    put(DAT, 1'b0, 1'b1, 3);
    check("relock_after_reset", symbol_lock_o, 1'b1);
    put(DAT, 1'b0, 1'b1, 3);

    gap(3);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rx_symbol_aligner.md
Name: rx_symbol_aligner

Overview:
- Per-lane receive-side 8b/10b symbol aligner, the receive counterpart of the transmit lane path.
- Accepts unaligned 10-bit parallel words from the electrical RX deserialiser and searches all 10 bit offsets for the K28.5 (COM) symbol.
- Acquires symbol lock and emits aligned 10-bit symbols to the downstream 8b/10b decoder and RX elastic buffer.
- Tracks code errors and misaligned commas to declare loss of lock.

Parameters:
- LOCK_COMMAS, 2: consecutive same-offset commas required to declare lock (range 1..15).
- ERR_THRESH, 4: error count that drops lock (range 1..15).
- GOOD_WINDOW, 16: consecutive error-free valid words that clear the error count (range 1..255).

Ports:
- clk_i  in  1  receive word clock.
- rst_i  in  1  asynchronous, active-high reset.
- raw_word_i  in  10  deserialised bits; bit 0 is the earliest received bit.
- raw_valid_i  in  1  raw_word_i valid this cycle.
- code_err_i  in  1  decoder reports a disparity or invalid-code error; acted on only in LOCKED.
- aligned_symbol_o  out  10  aligned symbol; bit 0 = bit 'a'.
- aligned_valid_o  out  1  aligned_symbol_o valid.
- is_comma_o  out  1  aligned_symbol_o is K28.5.
- symbol_lock_o  out  1  state is LOCKED.
- align_offset_o  out  4  current or candidate offset, 0..9.
- lock_lost_o  out  1  one-cycle pulse when LOCKED is exited.

Behaviour:
- Reset:
  - All outputs are 0.
  - State is UNALIGNED; prev word = 0; prev_seen = 0; all counters = 0.
- Window:
  - win[19:0] = {raw_word_i, prev}. Candidate at offset k = win[k+9:k].
  - On every raw_valid_i cycle: prev <= raw_word_i; prev_seen <= 1.
  - No search and no output until prev_seen = 1. The first valid word after reset only fills prev.
- Comma match:
  - Bit-0-first K28.5 equals 0011111010 (RD-) or 1100000101 (RD+).
  - Pattern constants: RD- = 10'h17C, RD+ = 10'h283 (bit 9 .. bit 0).
  - If several offsets match, the lowest k wins.
- Cycles with raw_valid_i = 0 change no state or counter, and aligned_valid_o = 0.
- States (evaluated only on raw_valid_i with prev_seen = 1):
  - UNALIGNED: a comma at offset k -> offset <= k, cnt <= 1. If LOCK_COMMAS = 1, go to LOCKED; otherwise go to CHECK.
  - CHECK, comma at the current offset: cnt++. When cnt reaches LOCK_COMMAS -> LOCKED, err_cnt <= 0, good_cnt <= 0.
  - CHECK, comma only at another offset j: offset <= j, cnt <= 1, stay in CHECK.
  - CHECK, no comma: hold.
  - LOCKED: offset is frozen.
    - error event = code_err_i, or a comma found at any offset other than the locked offset while none is found at the locked offset. Both in the same cycle count as a single error.
    - On an error event: err_cnt++, good_cnt <= 0.
    - On an error-free valid word: good_cnt++. When good_cnt reaches GOOD_WINDOW: err_cnt <= 0, good_cnt <= 0.
    - When err_cnt reaches ERR_THRESH: go to UNALIGNED, pulse lock_lost_o, clear cnt, err_cnt and good_cnt. prev and prev_seen are kept.
  - code_err_i outside LOCKED is ignored.
- Output registers (1-cycle latency from the qualifying raw_valid_i edge):
  - aligned_symbol_o = candidate at the offset in force after this cycle's update.
  - aligned_valid_o = 1 only when the next state is LOCKED. This includes the comma that completes lock and excludes the word that causes loss of lock.
  - is_comma_o = 1 only when aligned_valid_o = 1 and the symbol matches K28.5.
  - symbol_lock_o reflects the registered state.
  - align_offset_o is registered alongside the state.
- Asynchronous reset mid-lock forces the reset values immediately. After release, lock must be reacquired from scratch.

Test Plan:
- Stream with K28.5 (RD-) injected at offset 3, followed by D-symbols, with COM every 8 words, LOCK_COMMAS = 2 -> symbol_lock_o rises 1 cycle after the 2nd COM word; align_offset_o = 3; first aligned_valid_o carries 10'h17C with is_comma_o = 1.
- In CHECK at offset 3, a COM arrives at offset 7 -> offset changes to 7; lock is asserted only after a 2nd COM at offset 7; no aligned_valid_o before that.
- LOCKED, pulse code_err_i on 4 non-adjacent words with fewer than 16 good words between them -> lock_lost_o pulses once; symbol_lock_o = 0; aligned_valid_o = 0 on the 4th error word.
- LOCKED, 3 errors, then 16 clean words, then 3 more errors -> lock is held (err_cnt cleared after the window).
- In the same cycle, code_err_i = 1 and a COM at a wrong offset, repeated 4 times -> lock is lost on exactly the 4th such word (single count per cycle).
- Gaps of raw_valid_i = 0 inside a COM stream, plus rst_i asserted asynchronously mid-LOCKED -> gaps change nothing; reset drops all outputs to 0 immediately; relock takes 2 commas after the first post-reset fill word.
